rx_payload_buf_wr_splitter: RTL
===============================

// Module: rx_payload_buf_wr_splitter
// PURPOSE
//  Downstream of the RX store-buf copy stage. Takes one per-packet write request (flowid, wr_ptr, size)
//  plus its payload beats, and issues memory write requests into the flow's circular RX payload buffer.
//  Requests that run past the buffer end are split into two segments; segment-2 data is byte-realigned.
//  Signals completion so the upstream stage can advance the flow commit pointer.
// PARAMETERS
//  FLOWID_W     3        flow id width
//  PTR_W        16       buffer offset width; per-flow buffer size = 2**PTR_W bytes
//  SIZE_W       16       request size width (bytes)
//  DATA_W       512      beat width; B = DATA_W/8 bytes, byte 0 at bits [DATA_W-1 -: 8]
//  ADDR_W       40       memory address width
//  BUF_BASE     '0       base address of flow 0 buffer
// PORTS
//  clk                     in   1        clock
//  rst                     in   1        asynchronous reset, active-high
//  wr_buf_req_val          in   1        request valid
//  wr_buf_req_flowid       in   FLOWID_W flow
//  wr_buf_req_wr_ptr       in   PTR_W    start offset in flow buffer
//  wr_buf_req_size         in   SIZE_W   payload bytes (<= 2**PTR_W)
//  wr_buf_req_rdy          out  1        request accepted when val&rdy
//  wr_buf_req_data_val     in   1        payload beat valid
//  wr_buf_req_data         in   DATA_W   payload beat
//  wr_buf_req_data_rdy     out  1        beat consumed when val&rdy
//  mem_wr_req_val          out  1        memory write header valid
//  mem_wr_req_addr         out  ADDR_W   BUF_BASE + (flowid<<PTR_W) + segment offset
//  mem_wr_req_size         out  SIZE_W   segment bytes
//  mem_wr_req_rdy          in   1        header accepted
//  mem_wr_data_val         out  1        memory write beat valid
//  mem_wr_data             out  DATA_W   write beat (packed from byte 0 of segment)
//  mem_wr_data_last        out  1        final beat of segment
//  mem_wr_data_rdy         in   1        beat accepted
//  wr_buf_done_val         out  1        request fully written
//  wr_buf_done_rdy         in   1        done accepted
// BEHAVIOUR
//  - Reset (async): state IDLE; all *_val, *_rdy outputs and data/addr/size outputs = 0; hold reg cleared.
//  - FSM: IDLE -> SEG1_HDR -> SEG1_DATA -> [SEG2_HDR -> SEG2_DATA] -> DONE -> IDLE.
//    IDLE: wr_buf_req_rdy=1; on accept latch flowid/ptr/size; compute end = ptr + size (PTR_W+1 bits).
//      l1 = end>2**PTR_W ? 2**PTR_W-ptr : size; l2 = size-l1. size==0 -> DONE directly.
//    SEGn_HDR: mem_wr_req_val=1 (first cycle after accept); held until mem_wr_req_rdy. Seg2 offset = 0.
//    SEG1_DATA: ceil(l1/B) input beats passed straight through; last flagged mem_wr_data_last.
//      data_rdy = mem_wr_data_rdy (combinational pass, no bubble). If s=l1%B != 0, final seg1 input beat
//      is also copied into hold reg for seg2.
//    SEG2_DATA: ceil(l2/B) output beats. s==0: passthrough. s!=0: out_k = (hold<<8s) | (in>>8(B-s));
//      input consumed only when needed (total consumed = ceil(size/B)); missing tail bytes = 0.
//    DONE: wr_buf_done_val=1 until wr_buf_done_rdy; then IDLE. One done per request, after last beat.
//  - end == 2**PTR_W exactly: no split (l2=0). Offsets wrap mod 2**PTR_W.
//  - Output beats never emitted before their header is accepted; data input never consumed outside DATA states.
//  - Bytes past segment size in a beat are don't-care; memory writes only mem_wr_req_size bytes.
//  - Back-pressure on any output stalls FSM with outputs stable; no loss or duplication.
// TESTING (PTR_W=12, DATA_W=512, B=64, BUF_BASE=0)
//  1 flow 2, ptr 0x100, size 100 -> one hdr addr 0x2100 size 100; 2 beats, last on 2nd; one done.
//  2 flow 1, ptr 0xFC0, size 100 -> hdr 0x1FC0/64, 1 beat; hdr 0x1000/36, 1 beat (=input beat 1); done.
//  3 flow 0, ptr 0xFF0, size 100 -> hdr 0xFF0/16 (beat0); hdr 0x000/84: beats = in bytes 16..79, 80..99+zeros.
//  4 size 0 -> accepted, done_val 1 cycle later, no mem traffic, no data beats consumed.
//  5 case 3 with mem_wr_data_rdy toggling every cycle, done_rdy held low 5 cycles -> identical data, stall ok.
//  6 assert rst during SEG2_DATA -> outputs 0 immediately; following case-1 request completes correctly.

Source files
------------

// File: rtl/rx_payload_buf_wr_splitter.sv
// Splits one per-packet payload write into one or two memory write segments of a flow's
// circular RX buffer; the segment after the wrap point is byte-realigned from a hold beat.
module rx_payload_buf_wr_splitter #(
    parameter int                FLOWID_W = 3,
    parameter int                PTR_W    = 16,
    parameter int                SIZE_W   = 16,
    parameter int                DATA_W   = 512,
    parameter int                ADDR_W   = 40,
    parameter logic [ADDR_W-1:0] BUF_BASE = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_buf_req_val,
    input  logic [FLOWID_W-1:0] wr_buf_req_flowid,
    input  logic [PTR_W-1:0]    wr_buf_req_wr_ptr,
    input  logic [SIZE_W-1:0]   wr_buf_req_size,
    output logic                wr_buf_req_rdy,
    input  logic                wr_buf_req_data_val,
    input  logic [DATA_W-1:0]   wr_buf_req_data,
    output logic                wr_buf_req_data_rdy,
    output logic                mem_wr_req_val,
    output logic [ADDR_W-1:0]   mem_wr_req_addr,
    output logic [SIZE_W-1:0]   mem_wr_req_size,
    input  logic                mem_wr_req_rdy,
    output logic                mem_wr_data_val,
    output logic [DATA_W-1:0]   mem_wr_data,
    output logic                mem_wr_data_last,
    input  logic                mem_wr_data_rdy,
    output logic                wr_buf_done_val,
    input  logic                wr_buf_done_rdy
);
    localparam int B  = DATA_W / 8;
    localparam int BL = $clog2(B);
    localparam int CW = ((SIZE_W > PTR_W) ? SIZE_W : PTR_W) + 2;
    localparam logic [BL:0] B_CNT = (BL+1)'(B);

    typedef enum logic [2:0] {IDLE, SEG1_HDR, SEG1_DATA, SEG2_HDR, SEG2_DATA, DONE} state_t;

    state_t              state_reg;
    logic                req_rdy_reg;
    logic [FLOWID_W-1:0] flowid_reg;
    logic [SIZE_W-1:0]   l2_reg;
    logic [BL-1:0]       shift_reg;
    logic [SIZE_W-1:0]   out_rem_reg;
    logic [SIZE_W-1:0]   in_rem_reg;
    logic [DATA_W-1:0]   hold_reg;
    logic [ADDR_W-1:0]   hdr_addr_reg;
    logic [SIZE_W-1:0]   hdr_size_reg;

    function automatic logic [SIZE_W-1:0] ceil_beats(input logic [CW-1:0] n);
        logic [CW-1:0] t;
        t = (n + CW'(B-1)) >> BL;
        return t[SIZE_W-1:0];
    endfunction

    logic [CW-1:0] ptr_ext, size_ext, end_ext, buf_sz, l1_ext, l2_ext;
    assign ptr_ext  = CW'(wr_buf_req_wr_ptr);
    assign size_ext = CW'(wr_buf_req_size);
    assign end_ext  = ptr_ext + size_ext;
    assign buf_sz   = CW'(1) << PTR_W;
    assign l1_ext   = (end_ext > buf_sz) ? (buf_sz - ptr_ext) : size_ext;
    assign l2_ext   = size_ext - l1_ext;

    logic [ADDR_W-1:0] new_flow_base, cur_flow_base;
    assign new_flow_base = BUF_BASE + (ADDR_W'(wr_buf_req_flowid) << PTR_W);
    assign cur_flow_base = BUF_BASE + (ADDR_W'(flowid_reg) << PTR_W);

    logic          need_in;
    logic          data_fire;
    logic [BL:0]   rshift;
    assign need_in   = (state_reg == SEG1_DATA) || (in_rem_reg != '0);
    assign data_fire = mem_wr_data_val && mem_wr_data_rdy;
    assign rshift    = B_CNT - {1'b0, shift_reg};

    assign wr_buf_req_rdy  = req_rdy_reg;
    assign mem_wr_req_val  = (state_reg == SEG1_HDR) || (state_reg == SEG2_HDR);
    assign mem_wr_req_addr = hdr_addr_reg;
    assign mem_wr_req_size = hdr_size_reg;
    assign wr_buf_done_val = (state_reg == DONE);

    // Data path is combinational so beats flow without bubbles; gated to zero outside DATA states.
    always_comb begin
        mem_wr_data_val     = 1'b0;
        mem_wr_data         = '0;
        mem_wr_data_last    = 1'b0;
        wr_buf_req_data_rdy = 1'b0;
        if (state_reg == SEG1_DATA) begin
            mem_wr_data_val     = wr_buf_req_data_val;
            mem_wr_data         = wr_buf_req_data;
            mem_wr_data_last    = (out_rem_reg == SIZE_W'(1));
            wr_buf_req_data_rdy = mem_wr_data_rdy;
        end else if (state_reg == SEG2_DATA) begin
            mem_wr_data_val     = need_in ? wr_buf_req_data_val : 1'b1;
            mem_wr_data_last    = (out_rem_reg == SIZE_W'(1));
            wr_buf_req_data_rdy = need_in && mem_wr_data_rdy;
            if (shift_reg == '0)
                mem_wr_data = wr_buf_req_data;
            else
                mem_wr_data = (hold_reg << {shift_reg, 3'b000}) |
                              (need_in ? (wr_buf_req_data >> {rshift, 3'b000}) : '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            req_rdy_reg  <= 1'b0;
            flowid_reg   <= '0;
            l2_reg       <= '0;
            shift_reg    <= '0;
            out_rem_reg  <= '0;
            in_rem_reg   <= '0;
            hold_reg     <= '0;
            hdr_addr_reg <= '0;
            hdr_size_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (wr_buf_req_val && req_rdy_reg) begin
                        req_rdy_reg  <= 1'b0;
                        flowid_reg   <= wr_buf_req_flowid;
                        l2_reg       <= SIZE_W'(l2_ext);
                        shift_reg    <= l1_ext[BL-1:0];
                        out_rem_reg  <= ceil_beats(l1_ext);
                        in_rem_reg   <= ceil_beats(size_ext);
                        hdr_addr_reg <= new_flow_base + ADDR_W'(wr_buf_req_wr_ptr);
                        hdr_size_reg <= SIZE_W'(l1_ext);
                        state_reg    <= (wr_buf_req_size == '0) ? DONE : SEG1_HDR;
                    end else begin
                        req_rdy_reg <= 1'b1;
                    end
                end
                SEG1_HDR: if (mem_wr_req_rdy) state_reg <= SEG1_DATA;
                SEG1_DATA: begin
                    if (data_fire) begin
                        out_rem_reg <= out_rem_reg - SIZE_W'(1);
                        in_rem_reg  <= in_rem_reg - SIZE_W'(1);
                        if (mem_wr_data_last) begin
                            // Tail of the last seg1 beat becomes the head of seg2.
                            if (shift_reg != '0) hold_reg <= wr_buf_req_data;
                            hdr_addr_reg <= cur_flow_base;
                            hdr_size_reg <= l2_reg;
                            out_rem_reg  <= ceil_beats(CW'(l2_reg));
                            state_reg    <= (l2_reg != '0) ? SEG2_HDR : DONE;
                        end
                    end
                end
                SEG2_HDR: if (mem_wr_req_rdy) state_reg <= SEG2_DATA;
                SEG2_DATA: begin
                    if (data_fire) begin
                        out_rem_reg <= out_rem_reg - SIZE_W'(1);
                        if (need_in) begin
                            in_rem_reg <= in_rem_reg - SIZE_W'(1);
                            hold_reg   <= wr_buf_req_data;
                        end
                        if (mem_wr_data_last) state_reg <= DONE;
                    end
                end
                DONE: begin
                    if (wr_buf_done_rdy) begin
                        state_reg   <= IDLE;
                        req_rdy_reg <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule
